// File: rtl/lo_pkg.sv
// lo_pkg: constants and table shared by the LO sine generator and the
// coherent I/Q detector, so both sides always use the same 16-point sine.
//   LO_LEN       table length (one LO period in samples)
//   LO_SAMPLE_W  width of the signed sample path
//   SIN_TABLE    signed 8-bit sine, amplitude 100
//   sin_at/cos_at  lookups; cos is the sine a quarter period (4 steps) ahead
package lo_pkg;

  localparam int LO_LEN      = 16;
  localparam int LO_SAMPLE_W = 9;

  localparam logic signed [7:0] SIN_TABLE [LO_LEN] = '{
    8'sd0,    8'sd38,   8'sd71,   8'sd92,
    8'sd100,  8'sd92,   8'sd71,   8'sd38,
    8'sd0,   -8'sd38,  -8'sd71,  -8'sd92,
   -8'sd100, -8'sd92,  -8'sd71,  -8'sd38
  };

  function automatic logic signed [7:0] sin_at(input logic [3:0] k);
    return SIN_TABLE[k];
  endfunction

  // The 4-bit sum wraps naturally, giving (k+4) mod 16.
  function automatic logic signed [7:0] cos_at(input logic [3:0] k);
    logic [3:0] kc;
    kc = k + 4'd4;
    return SIN_TABLE[kc];
  endfunction

endpackage

// File: rtl/lo_iq_detect_if.sv
// lo_iq_detect_if: sample-in / result-out bundle of the I/Q tone detector.
//   sync, in_valid, in_sample   sample stream and phase realign (master -> slave)
//   out_valid                   one-cycle result strobe (slave -> master)
//   i_out, q_out                signed correlation sums, ACC_W bits
//   mag                         |i_out| + |q_out|, ACC_W+1 bits
//   detect                      mag >= threshold, held between results
interface lo_iq_detect_if #(
  parameter int ACC_W = 23
) ();
  import lo_pkg::*;

  logic                          sync;
  logic                          in_valid;
  logic signed [LO_SAMPLE_W-1:0] in_sample;
  logic                          out_valid;
  logic signed [ACC_W-1:0]       i_out;
  logic signed [ACC_W-1:0]       q_out;
  logic        [ACC_W:0]         mag;
  logic                          detect;

  modport master (
    output sync, in_valid, in_sample,
    input  out_valid, i_out, q_out, mag, detect
  );

  modport slave (
    input  sync, in_valid, in_sample,
    output out_valid, i_out, q_out, mag, detect
  );

endinterface

// File: rtl/lo_quad_rom.sv
// lo_quad_rom: combinational quadrature lookup of the shared LO table.
//   k        4-bit phase index
//   sin_val  sin[k], signed 8-bit
//   cos_val  sin[(k+4) mod 16], signed 8-bit
module lo_quad_rom
  import lo_pkg::*;
(
  input  logic [3:0]        k,
  output logic signed [7:0] sin_val,
  output logic signed [7:0] cos_val
);

  assign sin_val = sin_at(k);
  assign cos_val = cos_at(k);

endmodule

// File: rtl/lo_iq_detect.sv
// lo_iq_detect: coherent I/Q tone detector. Correlates the sample stream
// against the LO sine and cosine over N_PERIODS LO periods and reports the
// sums, an |I|+|Q| magnitude and a threshold flag at each window end.
//   clk    sole clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    lo_iq_detect_if slave: sync/in_valid/in_sample in,
//          out_valid/i_out/q_out/mag/detect out (all outputs registered)
// Pipeline: products registered on the accepting edge, accumulated on the
// next, results registered one edge later (out_valid 2 edges after the last
// sample of a window).
module lo_iq_detect
  import lo_pkg::*;
#(
  parameter int          N_PERIODS = 4,
  parameter int unsigned THRESH    = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  lo_iq_detect_if.slave  bus
);

  localparam int ACC_W  = 17 + $clog2(LO_LEN * N_PERIODS);
  localparam int PROD_W = LO_SAMPLE_W + 8;
  localparam int P_W    = (N_PERIODS > 1) ? $clog2(N_PERIODS) : 1;
  localparam logic [P_W-1:0] P_LAST   = P_W'(N_PERIODS - 1);
  localparam logic [ACC_W:0] THRESH_W = (ACC_W + 1)'(THRESH);

  // Extended before negation so the most negative sum cannot overflow.
  function automatic logic [ACC_W:0] abs_ext(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] w;
    w = (ACC_W + 1)'(v);
    return $unsigned((w < 0) ? -w : w);
  endfunction

  logic [3:0]               k, k_cur, k_nx;
  logic [P_W-1:0]           p, p_cur, p_nx;
  logic signed [7:0]        sin_k, cos_k;
  logic signed [PROD_W-1:0] ps_nx, pc_nx;
  logic signed [PROD_W-1:0] ps, pc;
  logic                     s1_valid, s1_last;
  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic signed [ACC_W-1:0]  base_i, base_q, acc_i_nx, acc_q_nx;
  logic                     s2_last;
  logic [ACC_W:0]           mag_nx;

  // sync makes the current sample (if any) phase 0 of a fresh window.
  assign k_cur = bus.sync ? 4'd0 : k;
  assign p_cur = bus.sync ? '0 : p;

  lo_quad_rom u_rom (
    .k       (k_cur),
    .sin_val (sin_k),
    .cos_val (cos_k)
  );

  always_comb begin
    k_nx = k_cur;
    p_nx = p_cur;
    if (bus.in_valid) begin
      k_nx = k_cur + 4'd1;
      if (k_cur == 4'd15) begin
        p_nx = (p_cur == P_LAST) ? '0 : p_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      p <= '0;
    end else begin
      k <= k_nx;
      p <= p_nx;
    end
  end

  assign ps_nx = PROD_W'(bus.in_sample) * PROD_W'(sin_k);
  assign pc_nx = PROD_W'(bus.in_sample) * PROD_W'(cos_k);

  // Stage 1: s1_valid follows in_valid every cycle so each product is
  // accumulated exactly once; product and last flag only load on a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      ps       <= '0;
      pc       <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        ps      <= ps_nx;
        pc      <= pc_nx;
        s1_last <= (k_cur == 4'd15) && (p_cur == P_LAST);
      end else if (bus.sync) begin
        s1_last <= 1'b0;
      end
    end
  end

  // While s2_last is set the accumulators hold a finished window that the
  // output stage is taking this cycle, so the next window starts from zero.
  always_comb begin
    base_i   = s2_last ? '0 : acc_i;
    base_q   = s2_last ? '0 : acc_q;
    acc_i_nx = base_i;
    acc_q_nx = base_q;
    if (s1_valid) begin
      acc_i_nx = base_i + ACC_W'(ps);
      acc_q_nx = base_q + ACC_W'(pc);
    end
    mag_nx = abs_ext(acc_i) + abs_ext(acc_q);
  end

  // Stage 2: accumulate; sync discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i   <= '0;
      acc_q   <= '0;
      s2_last <= 1'b0;
    end else if (bus.sync) begin
      acc_i   <= '0;
      acc_q   <= '0;
      s2_last <= 1'b0;
    end else begin
      acc_i   <= acc_i_nx;
      acc_q   <= acc_q_nx;
      s2_last <= s1_valid && s1_last;
    end
  end

  // Output stage: results and detect hold until the next completed window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.i_out     <= '0;
      bus.q_out     <= '0;
      bus.mag       <= '0;
      bus.detect    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (s2_last && !bus.sync) begin
        bus.out_valid <= 1'b1;
        bus.i_out     <= acc_i;
        bus.q_out     <= acc_q;
        bus.mag       <= mag_nx;
        bus.detect    <= (mag_nx >= THRESH_W);
      end
    end
  end

endmodule

// File: doc/lo_iq_detect.md
# lo_iq_detect

Coherent I/Q tone detector: the receive-side counterpart of the 16-point LO sine generator. It correlates a stream of signed 9-bit samples against the same 16-entry sine table and its quarter-period-shifted cosine over a window of N LO periods. At each window end it reports accumulated I, Q, a magnitude estimate, and a detect flag. It sits after the mixer/ADC sample path and consumes samples at the LO table rate of one table step per accepted sample.

## Interface
- N_PERIODS, 4: LO periods per integration window. Window = 16·N_PERIODS samples. Legal range is 1..16.
- THRESH, 100000: unsigned detect threshold, compared against mag.
- ACC_W, localparam = 17 + clog2(16·N_PERIODS): accumulator width. For the default, ACC_W = 23.
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- sync  in  1  phase realign. Restarts the window at table index 0.
- in_valid  in  1  sample strobe. No backpressure; every strobed sample is consumed.
- in_sample  in  9  signed input sample.
- out_valid  out  1  one-cycle pulse when i_out, q_out, mag and detect update.
- i_out  out  ACC_W  signed Σ x·sin[k].
- q_out  out  ACC_W  signed Σ x·cos[k], where cos[k] = sin[(k+4) mod 16].
- mag  out  ACC_W+1  unsigned |i_out|+|q_out|.
- detect  out  1  mag ≥ THRESH. Held until the next out_valid.

## Operation
- Sine table, signed 8-bit, k = 0..15: 0, 38, 71, 92, 100, 92, 71, 38, 0, −38, −71, −92, −100, −92, −71, −38.
- Phase index k is a 4-bit counter. It advances by 1 on each accepted sample, wrapping 15→0. Period counter p runs 0..N_PERIODS−1 and advances when k wraps.
- Stage 1, registered on in_valid: ps = x·sin[k] and pc = x·cos[k], each 17-bit signed. A last flag is registered with them when k = 15 and p = N_PERIODS−1.
- Stage 2: acc_i += ps and acc_q += pc, full ACC_W signed arithmetic with no saturation. Worst case is 256·1004·N_PERIODS, which fits ACC_W by construction.
- On a stage-2 update carrying last:
  - i_out and q_out take the final sums, and mag is computed from them.
  - detect updates and out_valid pulses.
  - Both accumulators restart at 0 for the next window; no sample is lost across the boundary.
- Gaps in in_valid freeze k, p, the pipeline flags and the accumulators. Products are only ever used with their own valid bit.
- sync high, taking priority over everything else:
  - k, p, acc_i, acc_q and pipeline valid/last flags clear; any partial window is discarded with no out_valid.
  - If in_valid is high in the same cycle, that sample is accepted as k = 0, p = 0 of the new window.
  - i_out, q_out, mag and detect keep their last reported values.
- Reset, including mid-window: every register clears. i_out = 0, q_out = 0, mag = 0, detect = 0, out_valid = 0, k = 0, p = 0.

## Timing
- Sample accepted on edge t feeds stage 1 at t. Its product is accumulated at t+1.
- out_valid rises at edge t+2 after the last sample of a window is accepted at t. Latency is 2 cycles.
- With back-to-back in_valid, the window period is 16·N_PERIODS cycles and out_valid is a single-cycle pulse every window.
- No combinational path runs from inputs to outputs.

## Structure
- Shared package lo_pkg holds:
  - LO_LEN = 16 and LO_SAMPLE_W = 9;
  - the 16-entry sine constant array;
  - sin_at(k) and cos_at(k) functions.
- The LO generator and this block both use lo_pkg, so their tables cannot diverge.
- One sub-module, lo_quad_rom: combinational lookup from 4-bit k to signed 8-bit sin and cos.
- The rest stays in one module: phase/period counters, two-stage MAC pipeline, and output registers.

## Test plan
All scenarios use the defaults (N_PERIODS = 4, THRESH = 100000) and contiguous in_valid unless stated.
- Input sin[k] aligned by sync, 64 samples → one out_valid: i_out = 319184, q_out = 0, mag = 319184, detect = 1.
- Input cos[k], i.e. sin[(k+4) mod 16] → i_out = 0, q_out = 319184, detect = 1.
- Constant 100 or all zeros → i_out = 0, q_out = 0, mag = 0, detect = 0.
- Input sin[k] with in_valid toggled 1-0-1-0 for 128 cycles → results identical to the first case; out_valid arrives 2 cycles after the 64th accepted sample.
- Assert sync at sample 20 of a window, coincident with in_valid → no out_valid for the aborted window. The next out_valid arrives 64 samples after sync, with first-case values.
- Worst-case input x = 255 where sin[k] ≥ 0 and −256 where sin[k] < 0 → i_out = 1026088 with no wrap. Assert rst_n low mid-window → all outputs 0, then a clean restart.
